// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader and the memory it fills.
package imem_loader_pkg;
  localparam int DEF_ADDR_W = 9;
  localparam int DEF_DEPTH  = 512;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WRITE,
    ST_VERIFY,
    ST_DRAIN,
    ST_DONE
  } state_t;
endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-to-word assembler: bytes shift in from the top so byte 0 ends at the LSBs.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              byte_en,
  input  logic [7:0]        byte_in,
  output logic              last_byte,
  output logic [DATA_W-1:0] word,
  output logic              word_valid
);

  logic [1:0] byte_cnt;

  assign last_byte = (byte_cnt == 2'd3);

  // word_valid pulses the cycle after the 4th byte, when word holds the complete value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt   <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= byte_en & last_byte;
      if (clear) begin
        byte_cnt <= '0;
      end else if (byte_en) begin
        byte_cnt <= byte_cnt + 2'd1;
        word     <= {byte_in, word[DATA_W-1:8]};
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a byte stream into instruction memory, reads it back to compare XOR checksums, then releases the CPU.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   num_words,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_din,
  output logic              imem_wea,
  input  logic [DATA_W-1:0] imem_dout,
  output logic              busy,
  output logic              done,
  output logic              verify_err,
  output logic              cpu_run
);

  state_t            state, next_state;
  logic [ADDR_W-1:0] n_last, n_last_new;
  logic [ADDR_W:0]   n_clip;
  logic [DATA_W-1:0] wsum, rsum, rsum_final, word;
  logic              launch, byte_en, last_byte, at_last;

  assign in_ready   = (state == ST_LOAD);
  assign byte_en    = in_valid & in_ready;
  assign at_last    = (imem_addr == n_last);
  assign launch     = ((state == ST_IDLE) || (state == ST_DONE)) && start && (num_words != '0);
  assign n_clip     = (num_words > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : num_words;
  assign n_last_new = ADDR_W'(n_clip - (ADDR_W+1)'(1));
  assign rsum_final = rsum ^ imem_dout;
  assign imem_din   = word;

  imem_loader_byte_packer #(.DATA_W(DATA_W)) u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (launch),
    .byte_en    (byte_en),
    .byte_in    (in_data),
    .last_byte  (last_byte),
    .word       (word),
    .word_valid (imem_wea)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE, ST_DONE: if (launch) next_state = ST_LOAD;
      ST_LOAD:          if (byte_en && last_byte) next_state = ST_WRITE;
      ST_WRITE:         next_state = at_last ? ST_VERIFY : ST_LOAD;
      ST_VERIFY:        if (at_last) next_state = ST_DRAIN;
      ST_DRAIN:         next_state = ST_DONE;
      default:          next_state = ST_IDLE;
    endcase
  end

  // imem_addr doubles as the write word index and the verify read address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_last     <= '0;
      imem_addr  <= '0;
      wsum       <= '0;
      rsum       <= '0;
      verify_err <= 1'b0;
      cpu_run    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      busy <= next_state inside {ST_LOAD, ST_WRITE, ST_VERIFY, ST_DRAIN};
      done <= (next_state == ST_DONE);
      case (state)
        ST_IDLE, ST_DONE: begin
          if (launch) begin
            n_last     <= n_last_new;
            imem_addr  <= '0;
            wsum       <= '0;
            rsum       <= '0;
            verify_err <= 1'b0;
            cpu_run    <= 1'b0;
          end
        end
        ST_WRITE: begin
          wsum      <= wsum ^ word;
          imem_addr <= at_last ? '0 : imem_addr + ADDR_W'(1);
        end
        ST_VERIFY: begin
          // read data lags the address by one cycle, so address 0 has nothing to fold in yet
          if (imem_addr != '0) rsum <= rsum_final;
          if (!at_last) imem_addr <= imem_addr + ADDR_W'(1);
        end
        ST_DRAIN: begin
          rsum       <= rsum_final;
          verify_err <= (wsum != rsum_final);
          cpu_run    <= (wsum == rsum_final);
        end
        default: ;
      endcase
    end
  end

endmodule
